// File: rtl/pr_retire_unit_pkg.sv
// -----------------------------------------------------------------------------
// pr_retire_unit_pkg
// Shared constants, entry type and helpers for the 3-wide retirement buffer.
//   ROB_ADDR_W    : default entry index width (depth = 2**ROB_ADDR_W)
//   ROB_DEPTH     : default buffer depth
//   PHYS_REG_W    : default physical register tag width
//   RETIRE_WIDTH  : dispatch / writeback / retire width (3)
//   thermo_mask() : 0..3 -> 000/100/110/111 (slot 2 is the oldest slot)
// -----------------------------------------------------------------------------
`ifndef SYS_ROB_ADDR_WIDTH
`define SYS_ROB_ADDR_WIDTH 5
`endif
`ifndef SYS_PHYS_REG
`define SYS_PHYS_REG 6
`endif

package pr_retire_unit_pkg;

    localparam int unsigned ROB_ADDR_W   = `SYS_ROB_ADDR_WIDTH;
    localparam int unsigned ROB_DEPTH    = 2 ** ROB_ADDR_W;
    localparam int unsigned PHYS_REG_W   = `SYS_PHYS_REG;
    localparam int unsigned RETIRE_WIDTH = 3;

    typedef struct packed {
        logic                  valid;
        logic                  complete;
        logic                  has_dest;
        logic [PHYS_REG_W-1:0] told;
    } pr_retire_entry_t;

    // Oldest-first slot mask for a count of 0..3.
    function automatic logic [RETIRE_WIDTH-1:0] thermo_mask(input logic [1:0] n);
        logic [RETIRE_WIDTH-1:0] m;
        case (n)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b100;
            2'd2:    m = 3'b110;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pr_retire_select.sv
// -----------------------------------------------------------------------------
// pr_retire_select
// Combinational head-window scan. Slot 2 is the head entry, slot 1 head+1,
// slot 0 head+2. Retirement stops at the first entry that is not both valid
// and complete.
//   win_valid/win_complete/win_has_dest : per-slot entry flags
//   win_told                            : per-slot stale PR
//   retire_cnt                          : number of entries retiring (0..3)
//   rt_retire_mask                      : all retiring slots
//   fl_retire_en_mask                   : retiring slots that free a PR
//   fl_retired_pr_list                  : told per freeing slot, 0 otherwise
// -----------------------------------------------------------------------------
module pr_retire_select
    import pr_retire_unit_pkg::*;
#(
    parameter int unsigned PR_W = PHYS_REG_W
) (
    input  logic [RETIRE_WIDTH-1:0]           win_valid,
    input  logic [RETIRE_WIDTH-1:0]           win_complete,
    input  logic [RETIRE_WIDTH-1:0]           win_has_dest,
    input  logic [RETIRE_WIDTH-1:0][PR_W-1:0] win_told,
    output logic [1:0]                        retire_cnt,
    output logic [RETIRE_WIDTH-1:0]           rt_retire_mask,
    output logic [RETIRE_WIDTH-1:0]           fl_retire_en_mask,
    output logic [RETIRE_WIDTH-1:0][PR_W-1:0] fl_retired_pr_list
);

    logic [RETIRE_WIDTH-1:0] done;
    logic [RETIRE_WIDTH-1:0] run;

    always_comb begin
        done = win_valid & win_complete;
        // A younger slot may only retire if every older slot retires too.
        run[2] = done[2];
        run[1] = run[2] & done[1];
        run[0] = run[1] & done[0];

        retire_cnt        = {1'b0, run[2]} + {1'b0, run[1]} + {1'b0, run[0]};
        rt_retire_mask    = run;
        fl_retire_en_mask = run & win_has_dest;

        for (int unsigned s = 0; s < RETIRE_WIDTH; s++) begin
            fl_retired_pr_list[s] = fl_retire_en_mask[s] ? win_told[s] : '0;
        end
    end

endmodule

// File: rtl/pr_retire_unit.sv
// -----------------------------------------------------------------------------
// pr_retire_unit
// 3-wide in-order retirement buffer. Records each dispatched instruction's
// stale PR, collects completions from three writeback ports and retires up to
// three completed entries per cycle from the head, returning their stale PRs
// to the freelist. rec_enable flushes everything younger than the retiring
// group.
//   clk, rst            : clock, asynchronous active-high reset
//   disp_en_mask        : dispatch valids (slot 2 oldest)
//   disp_has_dest       : per-slot destination flag
//   disp_told_pr        : per-slot stale PR
//   disp_ready_mask     : slots accepted this cycle (000/100/110/111)
//   disp_idx            : entry index assigned last cycle per accepted slot
//   wb_valid, wb_idx    : completion ports
//   rec_enable          : branch recovery flush
//   fl_retire_en_mask   : retiring entries with a destination
//   fl_retired_pr_list  : told per freeing slot, 0 otherwise
//   rt_retire_mask      : all retiring entries
//   rt_head_ptr         : head index
//   rt_free_count       : free entries (0..depth)
// -----------------------------------------------------------------------------
module pr_retire_unit
    import pr_retire_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = ROB_ADDR_W,
    parameter int unsigned PR_W   = PHYS_REG_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [RETIRE_WIDTH-1:0]           disp_en_mask,
    input  logic [RETIRE_WIDTH-1:0]           disp_has_dest,
    input  logic [RETIRE_WIDTH-1:0][PR_W-1:0] disp_told_pr,
    output logic [RETIRE_WIDTH-1:0]           disp_ready_mask,
    output logic [RETIRE_WIDTH-1:0][ADDR_W-1:0] disp_idx,
    input  logic [RETIRE_WIDTH-1:0]           wb_valid,
    input  logic [RETIRE_WIDTH-1:0][ADDR_W-1:0] wb_idx,
    input  logic                              rec_enable,
    output logic [RETIRE_WIDTH-1:0]           fl_retire_en_mask,
    output logic [RETIRE_WIDTH-1:0][PR_W-1:0] fl_retired_pr_list,
    output logic [RETIRE_WIDTH-1:0]           rt_retire_mask,
    output logic [ADDR_W-1:0]                 rt_head_ptr,
    output logic [ADDR_W:0]                   rt_free_count
);

    localparam int unsigned      DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W:0]   count;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_complete;
    logic [DEPTH-1:0]  ent_has_dest;
    logic [PR_W-1:0]   ent_told [DEPTH];

    logic [ADDR_W:0]                      free_cnt;
    logic [1:0]                           free_sat;
    logic [RETIRE_WIDTH-1:0]              accept;
    logic [RETIRE_WIDTH-1:0][ADDR_W-1:0]  alloc_idx;
    logic [ADDR_W:0]                      alloc_cnt;

    logic [RETIRE_WIDTH-1:0][ADDR_W-1:0]  win_idx;
    logic [RETIRE_WIDTH-1:0]              win_valid;
    logic [RETIRE_WIDTH-1:0]              win_complete;
    logic [RETIRE_WIDTH-1:0]              win_has_dest;
    logic [RETIRE_WIDTH-1:0][PR_W-1:0]    win_told;
    logic [1:0]                           retire_cnt;
    logic [ADDR_W-1:0]                    head_next;

    // Space is judged from registered count only; entries retiring this
    // cycle are not reusable until the next cycle.
    always_comb begin
        free_cnt        = DEPTH_CNT - count;
        free_sat        = (free_cnt > (ADDR_W + 1)'(3)) ? 2'd3 : free_cnt[1:0];
        disp_ready_mask = thermo_mask(free_sat);
        accept          = disp_en_mask & disp_ready_mask;

        // Accepted slots take consecutive indices oldest first; disabled
        // slots do not consume an index.
        alloc_idx[2] = tail;
        alloc_idx[1] = tail + ADDR_W'(accept[2]);
        alloc_idx[0] = alloc_idx[1] + ADDR_W'(accept[1]);
        alloc_cnt    = (ADDR_W + 1)'(accept[2]) + (ADDR_W + 1)'(accept[1])
                     + (ADDR_W + 1)'(accept[0]);
    end

    always_comb begin
        for (int unsigned s = 0; s < RETIRE_WIDTH; s++) begin
            win_idx[s]      = head + ADDR_W'(RETIRE_WIDTH - 1 - s);
            win_valid[s]    = ent_valid[win_idx[s]];
            win_complete[s] = ent_complete[win_idx[s]];
            win_has_dest[s] = ent_has_dest[win_idx[s]];
            win_told[s]     = ent_told[win_idx[s]];
        end
    end

    pr_retire_select #(
        .PR_W (PR_W)
    ) u_select (
        .win_valid          (win_valid),
        .win_complete       (win_complete),
        .win_has_dest       (win_has_dest),
        .win_told           (win_told),
        .retire_cnt         (retire_cnt),
        .rt_retire_mask     (rt_retire_mask),
        .fl_retire_en_mask  (fl_retire_en_mask),
        .fl_retired_pr_list (fl_retired_pr_list)
    );

    assign head_next     = head + ADDR_W'(retire_cnt);
    assign rt_head_ptr   = head;
    assign rt_free_count = free_cnt;

    // Retirement is committed even during recovery; the flush then restarts
    // the buffer empty just past the retired group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            disp_idx <= '0;
        end else begin
            head <= head_next;
            if (rec_enable) begin
                tail     <= head_next;
                count    <= '0;
                disp_idx <= '0;
            end else begin
                tail  <= tail + ADDR_W'(alloc_cnt);
                count <= count + alloc_cnt - (ADDR_W + 1)'(retire_cnt);
                for (int unsigned s = 0; s < RETIRE_WIDTH; s++) begin
                    disp_idx[s] <= accept[s] ? alloc_idx[s] : '0;
                end
            end
        end
    end

    // Later assignments win: retire clears override completions, and
    // dispatch only targets entries that were free at the start of the cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid    <= '0;
            ent_complete <= '0;
        end else if (rec_enable) begin
            ent_valid    <= '0;
            ent_complete <= '0;
        end else begin
            for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
                if (wb_valid[i] && ent_valid[wb_idx[i]]) begin
                    ent_complete[wb_idx[i]] <= 1'b1;
                end
            end
            for (int unsigned s = 0; s < RETIRE_WIDTH; s++) begin
                if (rt_retire_mask[s]) begin
                    ent_valid[win_idx[s]]    <= 1'b0;
                    ent_complete[win_idx[s]] <= 1'b0;
                end
            end
            for (int unsigned s = 0; s < RETIRE_WIDTH; s++) begin
                if (accept[s]) begin
                    ent_valid[alloc_idx[s]]    <= 1'b1;
                    ent_complete[alloc_idx[s]] <= 1'b0;
                end
            end
        end
    end

    // Payload is only observed through valid entries, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < RETIRE_WIDTH; s++) begin
            if (accept[s] && !rec_enable) begin
                ent_has_dest[alloc_idx[s]] <= disp_has_dest[s];
                ent_told[alloc_idx[s]]     <= disp_told_pr[s];
            end
        end
    end

    a_no_dropped_dispatch : assert property (
        @(posedge clk) disable iff (rst)
        !rec_enable |-> ((disp_en_mask & ~disp_ready_mask) == 3'b000)
    );

endmodule

// File: doc/pr_retire_unit.md
Name: pr_retire_unit

Overview:
- 3-wide in-order retirement buffer (ROB-lite). Records each dispatched instruction's stale physical register (Told), collects completions from 3 writeback ports, and retires up to 3 completed instructions per cycle from the head.
- Drives the freelist return interface (fl_retire_en_mask / fl_retired_pr_list), so it sits between dispatch/writeback and the freelist.
- Owns the squash flush on branch recovery.

Parameters:
- ADDR_W, default `SYS_ROB_ADDR_WIDTH (5): entry index width. Depth = 2**ADDR_W.
- PR_W, default `SYS_PHYS_REG: physical register tag width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous reset, active-high.
- disp_en_mask, in, 3: dispatch valids. Slot 2 is the oldest, slot 0 the youngest.
- disp_has_dest, in, 3: per slot, the instruction writes a register.
- disp_told_pr, in, 3xPR_W: stale PR to free at retire.
- disp_ready_mask, out, 3: slots accepted this cycle: 000/100/110/111.
- disp_idx, out, 3xADDR_W: entry index assigned per enabled slot; 0 for disabled slots.
- wb_valid, in, 3: completion valids.
- wb_idx, in, 3xADDR_W: completing entry indices.
- rec_enable, in, 1: branch recovery flush.
- fl_retire_en_mask, out, 3: retired entries with a destination.
- fl_retired_pr_list, out, 3xPR_W: Told per retiring slot; 0 where the mask bit is 0.
- rt_retire_mask, out, 3: all retired entries (freelist-independent).
- rt_head_ptr, out, ADDR_W: head index.
- rt_free_count, out, ADDR_W+1: free entries, 0..2**ADDR_W.

Behaviour:
- State:
  - Per-entry: valid, complete, has_dest, told.
  - Pointers: head, tail (ADDR_W, wrap modulo depth).
  - count (ADDR_W+1): tracks occupancy, so full (count = depth) and empty (count = 0) are unambiguous.
- Reset (async):
  - head = tail = count = 0; all valid/complete = 0.
  - Outputs: disp_ready_mask = 111 (depth ≥ 3), rt_free_count = depth, all retire masks/lists 0, disp_idx all 0.
- Space:
  - free = depth − count, using registered count only. No same-cycle bypass of retirements.
  - disp_ready_mask: 000 if free=0, 100 if 1, 110 if 2, 111 if ≥3.
- Dispatch (registered, visible next cycle):
  - Enabled and ready slots are allocated oldest first: slot 2 first, then slot 1, then slot 0, skipping disabled slots.
  - Consecutive tail, tail+1, tail+2 indices are used only by enabled slots. For example, mask 101 gives slot2 → tail and slot0 → tail+1.
  - Each allocated entry is written valid=1, complete=0, and has_dest/told from its slot. tail advances by the number allocated.
  - Enabled but not-ready slots are dropped. A simulation assertion flags them.
- Completion:
  - wb_valid[i] sets complete[wb_idx[i]] at the next edge, only if that entry is valid. Otherwise it is ignored.
  - Duplicate indices across ports are harmless.
  - A completion does not enable retirement in the same cycle (1-cycle latency wb→retire).
- Retire (combinational outputs from registered state):
  - k = number of consecutive valid&complete entries starting at head, capped at 3.
  - rt_retire_mask: k=0 → 000, 1 → 100, 2 → 110, 3 → 111. Slot 2 = head, slot 1 = head+1, slot 0 = head+2.
  - fl_retire_en_mask = rt_retire_mask & has_dest of those entries, so gaps such as 101 are legal.
  - fl_retired_pr_list[s] = told of the slot's entry when its bit is set, else 0.
  - At the edge: retired entries are cleared, head += k, count += allocated − k. Count is bounded; wrap follows modulo depth.
- Simultaneous dispatch + retire: both apply; count nets the two.
- Full:
  - Dispatch is blocked while count = depth.
  - If head == tail, the valid bit at head disambiguates.
- rec_enable:
  - Retire outputs in that cycle are still driven and committed (the retiring branch may raise it).
  - At the edge: all valid/complete cleared, tail = head_next, count = 0.
  - Dispatch and completions in that cycle are discarded.
- Reset mid-operation: immediate async clear. Outputs return to reset values without waiting for a clock edge.

Decomposition:
- Shared package / sys_defs:
  - Constants: ROB_DEPTH = 2**`SYS_ROB_ADDR_WIDTH, RETIRE_WIDTH = 3.
  - Typedef pr_retire_entry_t {valid, complete, has_dest, told}.
- One natural sub-module: pr_retire_select, the combinational head-window scan producing k, rt_retire_mask, fl_retire_en_mask and fl_retired_pr_list.
- Pointer and storage logic stays in pr_retire_unit.

Test Plan (ADDR_W=3, depth 8):
- Reset, then dispatch 111 with told {slot2=9, slot1=10, slot0=11}, all has_dest.
  - Next cycle: rt_free_count=5, disp_idx = 0, 1, 2.
  - wb idx 0, 1, 2. The cycle after: rt_retire_mask=111, fl_retired_pr_list = {9, 10, 11}, then rt_free_count=8.
- Out-of-order completion: entries 0–2 dispatched; only idx 1 and 2 complete.
  - rt_retire_mask stays 000.
  - Complete idx 0 → next cycle mask 111.
- Entry 1 has has_dest=0, all complete → rt_retire_mask=111, fl_retire_en_mask=101, fl_retired_pr_list[1]=0.
- Fill to 8 entries:
  - Full: disp_ready_mask=000, rt_free_count=8→0, head==tail.
  - Drop to 6 valid: mask 110.
  - Retire across index 7→0: wrap works.
- rec_enable with head entry complete and 5 valid:
  - That cycle: retire mask 100 honoured.
  - Next cycle: count=0, tail=head=old head+1, ready=111.
  - A simultaneous dispatch is discarded.
- Assert rst asynchronously mid-dispatch → outputs reset immediately. A stale wb_idx after release is ignored (entry invalid).
